inst_encoder_loader: RTL
========================

Name: inst_encoder_loader

Overview:
Encodes decoded instruction fields back into 32-bit machine words and writes them sequentially into the R-type CPU's instruction memory. It is the inverse of the instruction field parser. It sits between the board/testbench program-entry source and the instruction memory write port. It is used to load a program before the CPU is released to run.

Parameters:
ADDR_W, 6, instruction memory word-address width
DEPTH, 64, maximum instructions per load session (must be <= 2**ADDR_W)
BASE_ADDR, 0, first word address written after start

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a load session (sampled only in IDLE and DONE)
in_valid  in  1  field tuple valid
in_ready  out  1  loader can accept a tuple this cycle
in_last  in  1  tuple is the final instruction of the program
OP  in  6  opcode, placed in word bits [31:26]
rs  in  5  source register, bits [25:21]
rt  in  5  second source/target register, bits [20:16]
rd  in  5  destination register, bits [15:11] (R-type only)
shamt  in  5  shift amount, bits [10:6] (R-type only)
func  in  6  function code, bits [5:0] (R-type only)
imm  in  16  immediate, bits [15:0] when OP != 0
mem_we  out  1  instruction memory write strobe
mem_addr  out  ADDR_W  word address for write
mem_wdata  out  32  encoded instruction word
busy  out  1  session in progress (LOAD or WRITE)
done  out  1  session complete, held until next start
inst_count  out  ADDR_W+1  instructions written this session
overflow  out  1  sticky: DEPTH reached without in_last

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. All outputs are 0: in_ready, mem_we, mem_addr, mem_wdata, busy, done, inst_count and overflow. Any instruction in flight is dropped and not written.
- Encoding:
  - OP==0 (R-type): word = {OP,rs,rt,rd,shamt,func}.
  - OP!=0: word = {OP,rs,rt,imm}; rd, shamt and func are ignored.
  - The mapping is pure bit concatenation. No width extension or arithmetic is applied.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD; addr register=BASE_ADDR, inst_count=0, overflow=0, done=0.
- LOAD:
  - busy=1; in_ready=1.
  - On in_valid&&in_ready: register the encoded word, the current address and in_last, then -> WRITE.
  - in_valid=0: remain in LOAD, outputs stable.
- WRITE (exactly one cycle):
  - mem_we=1; mem_addr and mem_wdata hold the registered values; in_ready=0; busy=1.
  - At end of cycle: inst_count+=1, addr+=1.
  - Latched in_last -> DONE.
  - Else inst_count+1==DEPTH -> DONE and set overflow=1.
  - Else -> LOAD.
- Latency: tuple accepted at edge N -> mem_we high in cycle N+1. Throughput is 1 instruction per 2 cycles. in_ready is low in WRITE; upstream holds in_valid and data per standard valid/ready rules.
- DONE:
  - done=1, busy=0, in_ready=0.
  - mem_addr and mem_wdata keep the last written values; inst_count is held.
  - start=1 -> new session as from IDLE, done cleared the next cycle.
- start asserted in LOAD or WRITE is ignored.
- Address wrap: addr increments modulo 2**ADDR_W. With BASE_ADDR+DEPTH > 2**ADDR_W, writes wrap to 0. This is legal, not flagged.
- mem_we is never high in two consecutive cycles.

Decomposition:
- Shared package cpu_isa_pkg:
  - field widths and bit positions (OP_MSB/LSB, RS_MSB/LSB, RT_, RD_, SHAMT_, FUNC_, IMM_)
  - OP_RTYPE=6'b000000
  - loader state enum {IDLE, LOAD, WRITE, DONE}
- The parser also uses the field widths and bit positions from cpu_isa_pkg, so both blocks share one definition.
- One sub-module, inst_packer: a combinational field-to-word encoder, the exact inverse of the field parser. The loader instantiates it ahead of the word register.

Test Plan:
- Reset then start. Send R-type OP=0, rs=1, rt=2, rd=3, shamt=0, func=0x20, in_last=1 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x00221820. Next cycle done=1, inst_count=1, overflow=0.
- I-type OP=0x08, rs=1, rt=2, imm=0x0005 -> mem_wdata=0x20220005. rd, shamt and func set to all-ones have no effect.
- Three back-to-back tuples with in_valid held high -> writes at addr 0, 1, 2 in cycles 1, 3, 5; in_ready toggles 1,0,1,0,1,0; last tuple has in_last=1 -> done, inst_count=3.
- DEPTH=4, five tuples, no in_last -> exactly 4 writes, overflow=1, done=1, in_ready=0, and the fifth tuple is not accepted.
- rst_n=0 in the cycle after an accept (WRITE pending) -> mem_we stays 0, all outputs 0, state IDLE; the next start restarts at BASE_ADDR.
- start pulsed in mid-LOAD -> inst_count and addr unchanged. ADDR_W=2, BASE_ADDR=3, DEPTH=3 -> writes to addr 3, 0, 1.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// Instruction-word field layout shared by the field parser and the program loader,
// plus the loader's state encoding.
package cpu_isa_pkg;

  localparam int WORD_W  = 32;
  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNC_W  = 6;
  localparam int IMM_W   = 16;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNC_MSB  = 5;
  localparam int FUNC_LSB  = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [SHAMT_W-1:0] shamt;
    logic [FUNC_W-1:0]  func;
    logic [IMM_W-1:0]   imm;
  } inst_fields_t;

endpackage

// File: rtl/inst_encoder_loader_if.sv
// Program-entry tuple handshake, instruction-memory write port and session status.
// master = tuple source / memory side, slave = the loader.
interface inst_encoder_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [5:0]        OP;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        func;
  logic [15:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   inst_count;
  logic              overflow;

  modport master (
    output start, in_valid, in_last, OP, rs, rt, rd, shamt, func, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, inst_count, overflow
  );

  modport slave (
    input  start, in_valid, in_last, OP, rs, rt, rd, shamt, func, imm,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, inst_count, overflow
  );
endinterface

// File: rtl/inst_encoder_loader_packer.sv
// Combinational field-to-word encoder; exact inverse of the instruction field parser.
module inst_packer
  import cpu_isa_pkg::*;
(
  input  inst_fields_t      fields_i,
  output logic [WORD_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    word_o[OP_MSB:OP_LSB] = fields_i.op;
    word_o[RS_MSB:RS_LSB] = fields_i.rs;
    word_o[RT_MSB:RT_LSB] = fields_i.rt;
    if (fields_i.op == OP_RTYPE) begin
      word_o[RD_MSB:RD_LSB]       = fields_i.rd;
      word_o[SHAMT_MSB:SHAMT_LSB] = fields_i.shamt;
      word_o[FUNC_MSB:FUNC_LSB]   = fields_i.func;
    end else begin
      word_o[IMM_MSB:IMM_LSB] = fields_i.imm;
    end
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Program loader: accepts decoded field tuples, encodes them and writes one word
// per two cycles into instruction memory starting at BASE_ADDR.
module inst_encoder_loader
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inst_encoder_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              ovf_q, ovf_d;

  inst_fields_t      fields;
  logic [WORD_W-1:0] packed_word;

  assign fields = '{op: bus.OP, rs: bus.rs, rt: bus.rt, rd: bus.rd,
                    shamt: bus.shamt, func: bus.func, imm: bus.imm};

  inst_packer u_packer (
    .fields_i (fields),
    .word_o   (packed_word)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = LOAD;
          addr_d  = BASE_L;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          wdata_d = packed_word;
          waddr_d = addr_q;
          last_d  = bus.in_last;
          state_d = WRITE;
        end
      end
      WRITE: begin
        cnt_d  = cnt_q + 1'b1;
        // Address wraps naturally modulo 2**ADDR_W.
        addr_d = addr_q + 1'b1;
        if (last_q) begin
          state_d = DONE;
        end else if (cnt_d == DEPTH_L) begin
          state_d = DONE;
          ovf_d   = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      waddr_q <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready   = (state_q == LOAD);
  assign bus.busy       = (state_q == LOAD) || (state_q == WRITE);
  assign bus.mem_we     = (state_q == WRITE);
  assign bus.done       = (state_q == DONE);
  assign bus.mem_addr   = waddr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.inst_count = cnt_q;
  assign bus.overflow   = ovf_q;

endmodule
